seq_chk_monitor: RTL and testbench
==================================

Name: seq_chk_monitor

Overview:
Synthesizable multi-thread sequence checker, the hardware counterpart of a clocked property of the form ev0 ##[min1:max1] ev1 ##[min2:max2] ... evN-1.
- Every sampling edge may start a new attempt, and overlapping attempts run in parallel threads.
- Reports pass/fail with start and fail timestamps and the offending step, and keeps coverage-style counters.
- Sits beside the DUT in the bench/emulation build and observes DUT signals as event bits.

Parameters:
NUM_STEPS, 4, events in the sequence (1..8)
MAX_DLY, 4, largest programmable inter-step delay (>=1)
NUM_THREADS, 4, concurrent attempts tracked
TS_W, 16, timestamp width
CNT_W, 16, counter width (saturating)

Ports:
clk  in  1  sampling clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  allow new attempts
clr  in  1  synchronous flush of threads, counters, overflow
report_start  in  1  1 = step-0 miss counts as failure (per-cycle assert semantics)
ev  in  NUM_STEPS  sampled events; ev[0] starts an attempt
dly_min  in  NUM_STEPS*DW  per-step min delay, DW=$clog2(MAX_DLY+1); field 0 unused
dly_max  in  NUM_STEPS*DW  per-step max delay; field 0 unused
pass_vld  out  1  >=1 attempt passed
pass_start_ts  out  TS_W  start time of reported pass
fail_vld  out  1  >=1 thread failed
fail_step  out  $clog2(NUM_STEPS)  offending step of reported failure
fail_start_ts  out  TS_W  start time of reported failure
fail_ts  out  TS_W  time of failing sample
start_fail  out  1  step-0 miss (report_start=1)
pass_cnt, fail_cnt, drop_cnt  out  CNT_W  totals
overflow  out  1  sticky: an attempt was dropped
busy  out  NUM_THREADS  thread occupancy

Behaviour:
- Reset (async, rst_n=0):
  - all outputs 0, threads IDLE, timestamp counter 0.
  - Reset mid-attempt discards every thread silently; no pass or fail is reported afterwards.
- Timestamp: free-running TS_W counter, +1 per clk, wraps.
- Outputs are registered. Events sampled at edge t are reported at t+1. Pulses last 1 cycle.
- Delay clamping: min is clamped to >=1, max is clamped to >=min, and both are clamped to <=MAX_DLY.
- Step 0 (edge t, enable=1):
  - ev[0]=1: allocate the lowest-index free thread with step=1, cnt=0, start_ts=ts.
  - If NUM_STEPS==1, report a pass instead of allocating.
  - No free thread: drop the attempt, drop_cnt++, overflow=1.
- ev[0]=0 with report_start=1: start_fail=1 and fail_cnt++. fail_vld and fail details are not driven for this case.
- enable=0: no new attempts; active threads continue.
- Thread FSM, IDLE -> WAIT(step, cnt). Each edge in WAIT: cnt++, then:
  - if min<=cnt<=max and ev[step] -> advance (step++, cnt=0). On the last step: pass, go IDLE.
  - else if cnt>=max -> fail with fail_step=step, fail_ts=ts, go IDLE.
- Matching rule: earliest match wins (first-match). There is no multi-match forking.
- Thread reuse: a thread that retires at edge t is free for allocation at t+1, never at the same edge.
- Simultaneous events:
  - pass_cnt and fail_cnt add the popcount of passes/fails that cycle.
  - Details come from the lowest-index thread.
  - Pass and fail from different threads in the same cycle are both reported.
- Counters saturate at all-ones.
- clr: all threads go IDLE, counters and overflow go to 0, and no pulses are issued that cycle. clr takes priority over new attempts.
- dly_* changes while busy!=0 give undefined attempt outcomes. The cnt>=max check still retires every thread within MAX_DLY cycles per step; the block never hangs.

Decomposition:
- Package seq_chk_pkg:
  - result enum (RES_NONE, RES_PASS, RES_FAIL)
  - clamp_dly function
  - width helper localparams
- Sub-module seq_chk_thread: one FSM per thread, instantiated NUM_THREADS times in a generate loop. The top level holds allocation, reporting priority, counters and the timestamp.

Test Plan:
1. Defaults, dly1=[1:1], dly2=[1:1], dly3=[2:2]; ev0@t0, ev1@t1, ev2@t2, ev3@t4 -> pass_vld@t5, pass_start_ts=t0, pass_cnt=1.
2. Same config; ev0@t0, ev1=0@t1 -> fail_vld@t2, fail_step=1, fail_start_ts=t0, fail_ts=t1, fail_cnt=1.
3. dly3=[1:3]: ev3@t5 -> pass@t6; ev3 never -> fail_step=3, fail_ts=t5.
4. NUM_THREADS=2, dly1=[4:4], ev0 high t0..t2 -> threads 0 and 1 busy; t2 attempt dropped -> drop_cnt=1, overflow=1@t3.
5. Two threads miss at the same edge -> fail_cnt+=2, details from thread 0. Then report_start=1 with ev0=0 for one edge -> start_fail pulse, fail_cnt+1.
6. rst_n low while 3 threads busy -> all outputs 0 immediately; after release, no pass/fail pulses and counters stay 0. clr mid-attempt behaves the same, synchronously.

Source files
------------

// File: rtl/seq_chk_pkg.sv
// seq_chk_pkg: shared types and helpers for the sequence checker.
//   res_e       : per-thread outcome reported in the cycle a thread retires
//   thr_state_e : thread FSM state, visible on each thread's state port
//   idx_w       : index width helper that never returns 0
//   clamp_dly   : clamps a programmed delay into [lo, hi]
package seq_chk_pkg;

    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_PASS = 2'd1,
        RES_FAIL = 2'd2
    } res_e;

    typedef enum logic {
        THR_IDLE = 1'b0,
        THR_WAIT = 1'b1
    } thr_state_e;

    // Smallest index width; a one-entry table still gets a 1-bit index.
    localparam int MIN_IDX_W = 1;

    function automatic int idx_w(input int n);
        return (n <= 2) ? MIN_IDX_W : $clog2(n);
    endfunction

    function automatic int clamp_dly(input int value, input int lo, input int hi);
        int r;
        r = value;
        if (r < lo) r = lo;
        if (r > hi) r = hi;
        return r;
    endfunction

endpackage

// File: rtl/seq_chk_thread.sv
// seq_chk_thread: one attempt of the sequence ev0 ##[min:max] ev1 ... evN-1.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   clr              synchronous flush to IDLE
//   alloc            start an attempt this edge (only honoured in IDLE)
//   ts               current timestamp, latched as the start time
//   ev               sampled event bits
//   dly_min/dly_max  packed per-step delay windows (field 0 unused)
//   state            FSM state (IDLE / WAIT)
//   result           outcome for this edge, combinational, valid with state
//   step             step being waited for (the offending step on a fail)
//   start_ts         start timestamp of the running attempt
module seq_chk_thread
    import seq_chk_pkg::*;
#(
    parameter int NUM_STEPS = 4,
    parameter int MAX_DLY   = 4,
    parameter int TS_W      = 16,
    parameter int DW        = $clog2(MAX_DLY + 1),
    parameter int SW        = idx_w(NUM_STEPS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    alloc,
    input  logic [TS_W-1:0]         ts,
    input  logic [NUM_STEPS-1:0]    ev,
    input  logic [NUM_STEPS*DW-1:0] dly_min,
    input  logic [NUM_STEPS*DW-1:0] dly_max,
    output thr_state_e              state,
    output res_e                    result,
    output logic [SW-1:0]           step,
    output logic [TS_W-1:0]         start_ts
);

    thr_state_e      state_n;
    logic [SW-1:0]   step_n;
    logic [DW-1:0]   cnt, cnt_n, cnt_inc;
    logic [DW-1:0]   cur_min, cur_max;
    logic [TS_W-1:0] start_ts_n;
    logic            hit, last;
    logic [DW-1:0]   min_f [NUM_STEPS];
    logic [DW-1:0]   max_f [NUM_STEPS];

    for (genvar s = 0; s < NUM_STEPS; s++) begin : g_field
        assign min_f[s] = dly_min[s*DW +: DW];
        assign max_f[s] = dly_max[s*DW +: DW];
    end

    always_comb begin
        cur_min    = DW'(clamp_dly(int'(min_f[step]), 1, MAX_DLY));
        cur_max    = DW'(clamp_dly(int'(max_f[step]), int'(cur_min), MAX_DLY));
        cnt_inc    = cnt + DW'(1);
        hit        = (cnt_inc >= cur_min) && (cnt_inc <= cur_max) && ev[step];
        last       = (int'(step) == NUM_STEPS - 1);
        state_n    = state;
        step_n     = step;
        cnt_n      = cnt;
        start_ts_n = start_ts;
        result     = RES_NONE;
        if (clr) begin
            state_n = THR_IDLE;
        end else begin
            case (state)
                THR_IDLE: begin
                    if (alloc) begin
                        state_n    = THR_WAIT;
                        step_n     = SW'(1);
                        cnt_n      = '0;
                        start_ts_n = ts;
                    end
                end
                THR_WAIT: begin
                    // First match wins: the earliest in-window event advances.
                    if (hit) begin
                        if (last) begin
                            result  = RES_PASS;
                            state_n = THR_IDLE;
                        end else begin
                            step_n = step + SW'(1);
                            cnt_n  = '0;
                        end
                    end else if (cnt_inc >= cur_max) begin
                        // Also bounds the wait if the window shrank mid-attempt.
                        result  = RES_FAIL;
                        state_n = THR_IDLE;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                default: state_n = THR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= THR_IDLE;
            step     <= '0;
            cnt      <= '0;
            start_ts <= '0;
        end else begin
            state    <= state_n;
            step     <= step_n;
            cnt      <= cnt_n;
            start_ts <= start_ts_n;
        end
    end

endmodule

// File: rtl/seq_chk_monitor.sv
// seq_chk_monitor: multi-thread checker for ev0 ##[min1:max1] ev1 ... evN-1.
// Every enabled edge with ev[0]=1 starts an attempt in the lowest free thread.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   enable                 allow new attempts
//   clr                    synchronous flush of threads, counters, overflow
//   report_start           count a missing ev[0] as a failure
//   ev                     sampled event bits
//   dly_min/dly_max        packed per-step windows, DW bits per step
//   pass_vld/pass_start_ts pass pulse and start time (lowest thread)
//   fail_vld/fail_step/fail_start_ts/fail_ts  fail pulse and details
//   start_fail             pulse on a step-0 miss
//   pass_cnt/fail_cnt/drop_cnt  saturating totals
//   overflow               sticky, set when an attempt is dropped
//   busy                   thread occupancy
// pass_vld, fail_vld and start_fail are one-cycle pulses with no backpressure:
// the observer must accept them in the cycle they appear.
module seq_chk_monitor
    import seq_chk_pkg::*;
#(
    parameter int NUM_STEPS   = 4,
    parameter int MAX_DLY     = 4,
    parameter int NUM_THREADS = 4,
    parameter int TS_W        = 16,
    parameter int CNT_W       = 16,
    localparam int DW         = $clog2(MAX_DLY + 1),
    localparam int SW         = idx_w(NUM_STEPS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    clr,
    input  logic                    report_start,
    input  logic [NUM_STEPS-1:0]    ev,
    input  logic [NUM_STEPS*DW-1:0] dly_min,
    input  logic [NUM_STEPS*DW-1:0] dly_max,
    output logic                    pass_vld,
    output logic [TS_W-1:0]         pass_start_ts,
    output logic                    fail_vld,
    output logic [SW-1:0]           fail_step,
    output logic [TS_W-1:0]         fail_start_ts,
    output logic [TS_W-1:0]         fail_ts,
    output logic                    start_fail,
    output logic [CNT_W-1:0]        pass_cnt,
    output logic [CNT_W-1:0]        fail_cnt,
    output logic [CNT_W-1:0]        drop_cnt,
    output logic                    overflow,
    output logic [NUM_THREADS-1:0]  busy
);

    // Wide enough for every thread plus one step-0 event in a single cycle.
    localparam int PW = $clog2(NUM_THREADS + 2);

    logic [TS_W-1:0]        ts;
    thr_state_e             thr_state    [NUM_THREADS];
    res_e                   thr_res      [NUM_THREADS];
    logic [SW-1:0]          thr_step     [NUM_THREADS];
    logic [TS_W-1:0]        thr_start_ts [NUM_THREADS];
    logic [NUM_THREADS-1:0] thr_busy, first_free, alloc_vec;
    logic                   free_found, new_req, drop, start_pass, start_miss;
    logic                   pass_any, fail_any;
    logic [PW-1:0]          n_pass, n_fail;
    logic [TS_W-1:0]        pass_ts_sel, fail_ts_sel;
    logic [SW-1:0]          fail_step_sel;

    for (genvar i = 0; i < NUM_THREADS; i++) begin : g_thr
        seq_chk_thread #(
            .NUM_STEPS (NUM_STEPS),
            .MAX_DLY   (MAX_DLY),
            .TS_W      (TS_W),
            .DW        (DW),
            .SW        (SW)
        ) u_thr (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (clr),
            .alloc    (alloc_vec[i]),
            .ts       (ts),
            .ev       (ev),
            .dly_min  (dly_min),
            .dly_max  (dly_max),
            .state    (thr_state[i]),
            .result   (thr_res[i]),
            .step     (thr_step[i]),
            .start_ts (thr_start_ts[i])
        );
    end

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [PW-1:0]    inc);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W + 1 - PW){1'b0}}, inc};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    always_comb begin
        thr_busy      = '0;
        first_free    = '0;
        alloc_vec     = '0;
        free_found    = 1'b0;
        pass_any      = 1'b0;
        fail_any      = 1'b0;
        n_pass        = '0;
        n_fail        = '0;
        pass_ts_sel   = '0;
        fail_ts_sel   = '0;
        fail_step_sel = '0;
        start_pass    = 1'b0;
        drop          = 1'b0;
        // Ascending scan so the lowest index provides the reported details
        // and is the thread chosen for allocation.
        for (int i = 0; i < NUM_THREADS; i++) begin
            thr_busy[i] = (thr_state[i] == THR_WAIT);
            if (thr_res[i] == RES_PASS) begin
                if (!pass_any) pass_ts_sel = thr_start_ts[i];
                pass_any = 1'b1;
                n_pass   = n_pass + PW'(1);
            end
            if (thr_res[i] == RES_FAIL) begin
                if (!fail_any) begin
                    fail_ts_sel   = thr_start_ts[i];
                    fail_step_sel = thr_step[i];
                end
                fail_any = 1'b1;
                n_fail   = n_fail + PW'(1);
            end
            // A thread retiring this edge is still busy, so it is reused
            // no earlier than the next edge.
            if (!thr_busy[i] && !free_found) begin
                free_found    = 1'b1;
                first_free[i] = 1'b1;
            end
        end
        new_req    = enable && !clr && ev[0];
        start_miss = enable && !clr && !ev[0] && report_start;
        if (new_req) begin
            if (NUM_STEPS == 1) start_pass = 1'b1;
            else if (free_found) alloc_vec = first_free;
            else drop = 1'b1;
        end
        if (start_pass) begin
            if (!pass_any) pass_ts_sel = ts;
            pass_any = 1'b1;
            n_pass   = n_pass + PW'(1);
        end
        if (start_miss) n_fail = n_fail + PW'(1);
    end

    assign busy = thr_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts            <= '0;
            pass_vld      <= 1'b0;
            pass_start_ts <= '0;
            fail_vld      <= 1'b0;
            fail_step     <= '0;
            fail_start_ts <= '0;
            fail_ts       <= '0;
            start_fail    <= 1'b0;
            pass_cnt      <= '0;
            fail_cnt      <= '0;
            drop_cnt      <= '0;
            overflow      <= 1'b0;
        end else begin
            ts <= ts + TS_W'(1);
            if (clr) begin
                pass_vld   <= 1'b0;
                fail_vld   <= 1'b0;
                start_fail <= 1'b0;
                pass_cnt   <= '0;
                fail_cnt   <= '0;
                drop_cnt   <= '0;
                overflow   <= 1'b0;
            end else begin
                pass_vld   <= pass_any;
                fail_vld   <= fail_any;
                start_fail <= start_miss;
                if (pass_any) pass_start_ts <= pass_ts_sel;
                if (fail_any) begin
                    fail_step     <= fail_step_sel;
                    fail_start_ts <= fail_ts_sel;
                    fail_ts       <= ts;
                end
                pass_cnt <= sat_add(pass_cnt, n_pass);
                fail_cnt <= sat_add(fail_cnt, n_fail);
                drop_cnt <= sat_add(drop_cnt, PW'(drop));
                if (drop) overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_chk_monitor.sv
// tb_seq_chk_monitor: directed bench for seq_chk_monitor with an
// attempt-level reference model and a per-cycle compare process.
module tb_seq_chk_monitor;

    localparam int NS = 4;
    localparam int NT = 4;
    localparam int MD = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          clr = 1'b0;
    logic          report_start = 1'b0;
    logic [NS-1:0] ev = '0;
    logic [11:0]   dly_min = '0;
    logic [11:0]   dly_max = '0;

    logic          pass_vld, fail_vld, start_fail, overflow;
    logic [15:0]   pass_start_ts, fail_start_ts, fail_ts;
    logic [1:0]    fail_step;
    logic [15:0]   pass_cnt, fail_cnt, drop_cnt;
    logic [NT-1:0] busy;

    seq_chk_monitor #(
        .NUM_STEPS   (NS),
        .MAX_DLY     (MD),
        .NUM_THREADS (NT),
        .TS_W        (16),
        .CNT_W       (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .clr           (clr),
        .report_start  (report_start),
        .ev            (ev),
        .dly_min       (dly_min),
        .dly_max       (dly_max),
        .pass_vld      (pass_vld),
        .pass_start_ts (pass_start_ts),
        .fail_vld      (fail_vld),
        .fail_step     (fail_step),
        .fail_start_ts (fail_start_ts),
        .fail_ts       (fail_ts),
        .start_fail    (start_fail),
        .pass_cnt      (pass_cnt),
        .fail_cnt      (fail_cnt),
        .drop_cnt      (drop_cnt),
        .overflow      (overflow),
        .busy          (busy)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int start;
        int tid;
    } att_t;

    att_t          att_q[$];
    logic [NS-1:0] ev_hist[int];
    logic [15:0]   exp_q[$];
    int            cfg_min[NS];
    int            cfg_max[NS];
    int            m_e = 0;

    logic          e_pass_vld = 1'b0, e_fail_vld = 1'b0, e_start_fail = 1'b0, e_ovf = 1'b0;
    logic [1:0]    e_fail_step = '0;
    logic [15:0]   e_fail_start_ts = '0, e_fail_ts = '0;
    logic [15:0]   e_pass_cnt = '0, e_fail_cnt = '0, e_drop_cnt = '0;
    logic [NT-1:0] e_busy = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic logic [15:0] sat16(input logic [15:0] a, input int inc);
        int s;
        s = int'(a) + inc;
        return (s > 65535) ? 16'hFFFF : 16'(s);
    endfunction

    // Walks the recorded event history of one attempt. Returns 0 while the
    // attempt is undecided at edge 'now', 1 if it passes exactly at 'now',
    // 2 if it fails exactly at 'now' (rstep = the step that missed).
    function automatic int resolve(input int s0, input int now, output int rstep);
        int t, mn, mx;
        bit found;
        t = s0;
        rstep = 0;
        for (int s = 1; s < NS; s++) begin
            mn = clampi(cfg_min[s], 1, MD);
            mx = clampi(cfg_max[s], mn, MD);
            found = 1'b0;
            for (int d = mn; d <= mx; d++) begin
                if (t + d > now) return 0;
                if (ev_hist[t + d][s]) begin
                    t = t + d;
                    found = 1'b1;
                    break;
                end
            end
            if (!found) begin
                rstep = s;
                return (t + mx == now) ? 2 : 0;
            end
        end
        return (t == now) ? 1 : 0;
    endfunction

    task automatic model_reset();
        att_q.delete();
        ev_hist.delete();
        exp_q.delete();
        m_e = 0;
        e_pass_vld = 0; e_fail_vld = 0; e_start_fail = 0; e_ovf = 0;
        e_fail_step = '0; e_fail_start_ts = '0; e_fail_ts = '0;
        e_pass_cnt = '0; e_fail_cnt = '0; e_drop_cnt = '0; e_busy = '0;
    endtask

    task automatic model_step();
        int now, r, rs, np, nf, best_p, best_f, p_start, f_start, f_step, free_t;
        logic [NT-1:0] occ;
        att_t keep[$];
        now = m_e;
        ev_hist[now] = ev;
        e_pass_vld = 0; e_fail_vld = 0; e_start_fail = 0;
        np = 0; nf = 0; best_p = NT; best_f = NT;
        p_start = 0; f_start = 0; f_step = 0; occ = '0;
        if (clr) begin
            att_q.delete();
            e_pass_cnt = '0; e_fail_cnt = '0; e_drop_cnt = '0; e_ovf = 0; e_busy = '0;
        end else begin
            foreach (att_q[k]) begin
                occ[att_q[k].tid] = 1'b1;
                r = resolve(att_q[k].start, now, rs);
                if (r == 0) keep.push_back(att_q[k]);
                else if (r == 1) begin
                    np++;
                    if (att_q[k].tid < best_p) begin best_p = att_q[k].tid; p_start = att_q[k].start; end
                end else begin
                    nf++;
                    if (att_q[k].tid < best_f) begin
                        best_f = att_q[k].tid; f_start = att_q[k].start; f_step = rs;
                    end
                end
            end
            if (enable) begin
                if (ev[0]) begin
                    free_t = -1;
                    for (int i = NT - 1; i >= 0; i--) if (!occ[i]) free_t = i;
                    if (free_t >= 0) keep.push_back('{now, free_t});
                    else begin e_drop_cnt = sat16(e_drop_cnt, 1); e_ovf = 1; end
                end else if (report_start) begin
                    e_start_fail = 1;
                    nf++;
                end
            end
            att_q = keep;
            e_busy = '0;
            foreach (att_q[k]) e_busy[att_q[k].tid] = 1'b1;
            if (np > 0) begin
                e_pass_vld = 1;
                exp_q.push_back(16'(p_start));
            end
            if (best_f < NT) begin
                e_fail_vld = 1;
                e_fail_step = 2'(f_step);
                e_fail_start_ts = 16'(f_start);
                e_fail_ts = 16'(now);
            end
            e_pass_cnt = sat16(e_pass_cnt, np);
            e_fail_cnt = sat16(e_fail_cnt, nf);
        end
        m_e++;
    endtask

    initial begin : model
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin : compare
        logic [15:0] exp_ts;
        forever begin
            @(negedge clk);
            chk("pass_vld", pass_vld, e_pass_vld);
            chk("fail_vld", fail_vld, e_fail_vld);
            chk("start_fail", start_fail, e_start_fail);
            chk("pass_cnt", pass_cnt, e_pass_cnt);
            chk("fail_cnt", fail_cnt, e_fail_cnt);
            chk("drop_cnt", drop_cnt, e_drop_cnt);
            chk("overflow", overflow, e_ovf);
            chk("busy", busy, e_busy);
            if (e_pass_vld) begin
                exp_ts = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                chk("pass_start_ts", pass_start_ts, exp_ts);
            end
            if (e_fail_vld) begin
                chk("fail_step", fail_step, e_fail_step);
                chk("fail_start_ts", fail_start_ts, e_fail_start_ts);
                chk("fail_ts", fail_ts, e_fail_ts);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic set_dly(input int a0, input int a1, input int b0, input int b1,
                           input int c0, input int c1);
        cfg_min[0] = 0; cfg_max[0] = 0;
        cfg_min[1] = a0; cfg_max[1] = a1;
        cfg_min[2] = b0; cfg_max[2] = b1;
        cfg_min[3] = c0; cfg_max[3] = c1;
        dly_min = {3'(c0), 3'(b0), 3'(a0), 3'd0};
        dly_max = {3'(c1), 3'(b1), 3'(a1), 3'd0};
    endtask

    // Present one event vector for exactly one sampling edge.
    task automatic drive(input logic [NS-1:0] v);
        ev = v;
        @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin : main
        int t0;
        enable = 1'b1;
        set_dly(1, 1, 1, 1, 2, 2);
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_pass_cnt", pass_cnt, 0);
        chk("rst_pass_vld", pass_vld, 0);
        rst_n = 1'b1;
        drive(4'b0000);

        // 1: full pass, last step window [2:2]
        t0 = m_e;
        drive(4'b0001); drive(4'b0010); drive(4'b0100); drive(4'b0000);
        chk("t1_no_early_pass", pass_vld, 0);
        drive(4'b1000);
        chk("t1_pass_vld", pass_vld, 1);
        chk("t1_pass_start_ts", pass_start_ts, t0);
        chk("t1_pass_cnt", pass_cnt, 1);
        drive(4'b0000);

        // 2: miss on step 1; min 0 clamps up to 1
        set_dly(0, 1, 1, 1, 2, 2);
        t0 = m_e;
        drive(4'b0001); drive(4'b0000);
        chk("t2_fail_vld", fail_vld, 1);
        chk("t2_fail_step", fail_step, 1);
        chk("t2_fail_start_ts", fail_start_ts, t0);
        chk("t2_fail_ts", fail_ts, t0 + 1);
        chk("t2_fail_cnt", fail_cnt, 1);
        drive(4'b0000);

        // 3: last-step window [1:3], hit at the far edge, then miss
        set_dly(1, 1, 1, 1, 1, 3);
        drive(4'b0001); drive(4'b0010); drive(4'b0100);
        drive(4'b0000); drive(4'b0000); drive(4'b1000);
        chk("t3_pass_vld", pass_vld, 1);
        chk("t3_pass_cnt", pass_cnt, 2);
        t0 = m_e;
        drive(4'b0001); drive(4'b0010); drive(4'b0100);
        drive(4'b0000); drive(4'b0000); drive(4'b0000);
        chk("t3_fail_vld", fail_vld, 1);
        chk("t3_fail_step", fail_step, 3);
        chk("t3_fail_ts", fail_ts, t0 + 5);
        chk("t3_fail_cnt", fail_cnt, 2);
        drive(4'b0000);

        // enable=0 blocks new attempts
        enable = 1'b0;
        drive(4'b0001);
        chk("en_off_busy", busy, 0);
        enable = 1'b1;

        // 4: all threads busy; thread 0 retires on the fifth edge but is not
        // reusable until the next one, so the fifth attempt is dropped
        set_dly(4, 4, 1, 1, 1, 1);
        repeat (5) drive(4'b0001);
        chk("t4_drop_cnt", drop_cnt, 1);
        chk("t4_overflow", overflow, 1);
        chk("t4_busy", busy, 4'hE);
        repeat (8) drive(4'b0000);
        chk("t4_fail_cnt", fail_cnt, 6);

        // 5: two threads fail on the same edge; max 0 clamps up to min
        set_dly(1, 0, 1, 1, 1, 1);
        t0 = m_e;
        drive(4'b0001); drive(4'b0011); drive(4'b0000);
        chk("t5_fail_vld", fail_vld, 1);
        chk("t5_fail_step", fail_step, 2);
        chk("t5_fail_start_ts", fail_start_ts, t0);
        chk("t5_fail_cnt", fail_cnt, 8);
        report_start = 1'b1;
        drive(4'b0000);
        report_start = 1'b0;
        chk("t5_start_fail", start_fail, 1);
        chk("t5_start_no_fail_vld", fail_vld, 0);
        chk("t5_start_fail_cnt", fail_cnt, 9);

        // 6a: clr mid-attempt
        set_dly(4, 4, 1, 1, 1, 1);
        repeat (3) drive(4'b0001);
        chk("t6_clr_busy_before", busy, 4'h7);
        clr = 1'b1;
        drive(4'b0000);
        clr = 1'b0;
        chk("t6_clr_busy", busy, 0);
        chk("t6_clr_fail_cnt", fail_cnt, 0);
        chk("t6_clr_overflow", overflow, 0);
        chk("t6_clr_drop_cnt", drop_cnt, 0);
        repeat (6) drive(4'b0000);
        chk("t6_clr_fail_cnt_after", fail_cnt, 0);

        // 6b: async reset mid-attempt
        repeat (3) drive(4'b0001);
        chk("t6_rst_busy_before", busy, 4'h7);
        #2;
        rst_n = 1'b0;
        ev = '0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_pass_cnt", pass_cnt, 0);
        chk("t6_rst_fail_vld", fail_vld, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) drive(4'b0000);
        chk("t6_rst_fail_cnt_after", fail_cnt, 0);
        chk("t6_rst_pass_cnt_after", pass_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
